// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX->MEM pipeline latch.
// Latency: n/a (types only).
// Backpressure: n/a.
//
// mem_ctrl_t bundles the memory/writeback control bits that ride with each
// instruction. The MSB-to-LSB order is memtoreg, regwrite, memread, memwrite.
package ex_mem_pkg;

  localparam int CTRL_W   = 4;
  localparam int ZERO_REG = 0;

  typedef struct packed {
    logic memtoreg;
    logic regwrite;
    logic memread;
    logic memwrite;
  } mem_ctrl_t;

  localparam mem_ctrl_t CTRL_BUBBLE = mem_ctrl_t'(4'b0000);

  // An invalid slot must never assert a memory or writeback operation, so its
  // control bits are cleared at the point of load.
  function automatic mem_ctrl_t gate_ctrl(input logic valid, input mem_ctrl_t ctrl);
    return valid ? ctrl : CTRL_BUBBLE;
  endfunction

endpackage

// File: rtl/ex_mem_stage.sv
// One EX->MEM pipeline stage register: valid, control, ALU result, store data, dest reg.
// Latency: 1 cycle when i_load=1.
// Backpressure: none; i_load=0 holds the stage, i_bubble clears it regardless of i_load.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_load              advance enable (load the i_* values)
//   i_bubble            load an empty slot instead (wins over i_load)
//   i_valid/i_ctrl/i_alu/i_wd/i_wn   incoming slot contents
//   o_valid/o_ctrl/o_alu/o_wd/o_wn   registered slot contents
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_bubble,
  input  logic              i_valid,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_alu,
  input  logic [DATA_W-1:0] i_wd,
  input  logic [REG_AW-1:0] i_wn,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_alu,
  output logic [DATA_W-1:0] o_wd,
  output logic [REG_AW-1:0] o_wn
);

  logic              r_valid;
  mem_ctrl_t         r_ctrl;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_wd;
  logic [REG_AW-1:0] r_wn;

  always_ff @(posedge clk) begin
    if (rst || i_bubble) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_BUBBLE;
      r_alu   <= '0;
      r_wd    <= '0;
      r_wn    <= '0;
    end else if (i_load) begin
      // Data fields of an invalid slot pass through untouched; only the
      // control bits are suppressed.
      r_valid <= i_valid;
      r_ctrl  <= gate_ctrl(i_valid, mem_ctrl_t'(i_ctrl));
      r_alu   <= i_alu;
      r_wd    <= i_wd;
      r_wn    <= i_wn;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_alu   = r_alu;
  assign o_wd    = r_wd;
  assign o_wn    = r_wn;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline latch of DEPTH stages with stall, bubble insertion and forwarding query.
// Latency: DEPTH en_reg=1 cycles from input sample to outputs; forwarding is combinational.
// Backpressure: none internal; en_reg=0 holds every stage, flush empties stage 0.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   en_reg, flush                    advance enable, bubble into stage 0
//   valid_in, *_out_from_ID, alu_out, rfile_rd2_out, rfile_wn   instruction from EX
//   valid_out, *_out_from_EX, alu_out_out, mem_wd, rfile_wn_out final-stage contents
//   fwd_rs -> fwd_hit, fwd_data, fwd_load    forwarding query over in-flight stages
// Build option: define EX_MEM_PIPE_FWD_EN to compile in the forwarding match logic;
// without it the forwarding outputs are tied to 0. DEPTH must be in 1..4.
module ex_mem_pipe
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_reg,
  input  logic              flush,
  input  logic              valid_in,
  input  logic              MemtoReg_out_from_ID,
  input  logic              RegWrite_out_from_ID,
  input  logic              MemRead_out_from_ID,
  input  logic              MemWrite_out_from_ID,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] rfile_rd2_out,
  input  logic [REG_AW-1:0] rfile_wn,
  output logic              valid_out,
  output logic              MemtoReg_out_from_EX,
  output logic              RegWrite_out_from_EX,
  output logic              MemRead_out_from_EX,
  output logic              MemWrite_out_from_EX,
  output logic [DATA_W-1:0] alu_out_out,
  output logic [DATA_W-1:0] mem_wd,
  output logic [REG_AW-1:0] rfile_wn_out,
  input  logic [REG_AW-1:0] fwd_rs,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              fwd_load
);

  // Per-stage register outputs; index 0 is the youngest stage.
  logic              w_valid [DEPTH];
  mem_ctrl_t         w_ctrl  [DEPTH];
  logic [DATA_W-1:0] w_alu   [DEPTH];
  logic [DATA_W-1:0] w_wd    [DEPTH];
  logic [REG_AW-1:0] w_wn    [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic              w_d_valid;
    logic [CTRL_W-1:0] w_d_ctrl;
    logic [DATA_W-1:0] w_d_alu;
    logic [DATA_W-1:0] w_d_wd;
    logic [REG_AW-1:0] w_d_wn;
    logic              w_bubble;

    if (k == 0) begin : g_head
      assign w_d_valid = valid_in;
      assign w_d_ctrl  = {MemtoReg_out_from_ID, RegWrite_out_from_ID,
                          MemRead_out_from_ID, MemWrite_out_from_ID};
      assign w_d_alu   = alu_out;
      assign w_d_wd    = rfile_rd2_out;
      assign w_d_wn    = rfile_wn;
      // Flush only ever touches the youngest stage, stalled or not.
      assign w_bubble  = flush;
    end else begin : g_tail
      assign w_d_valid = w_valid[k-1];
      assign w_d_ctrl  = w_ctrl[k-1];
      assign w_d_alu   = w_alu[k-1];
      assign w_d_wd    = w_wd[k-1];
      assign w_d_wn    = w_wn[k-1];
      assign w_bubble  = 1'b0;
    end

    ex_mem_stage #(
      .DATA_W(DATA_W),
      .REG_AW(REG_AW)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_load  (en_reg),
      .i_bubble(w_bubble),
      .i_valid (w_d_valid),
      .i_ctrl  (w_d_ctrl),
      .i_alu   (w_d_alu),
      .i_wd    (w_d_wd),
      .i_wn    (w_d_wn),
      .o_valid (w_valid[k]),
      .o_ctrl  (w_ctrl[k]),
      .o_alu   (w_alu[k]),
      .o_wd    (w_wd[k]),
      .o_wn    (w_wn[k])
    );
  end

  assign valid_out            = w_valid[DEPTH-1];
  assign MemtoReg_out_from_EX = w_ctrl[DEPTH-1].memtoreg;
  assign RegWrite_out_from_EX = w_ctrl[DEPTH-1].regwrite;
  assign MemRead_out_from_EX  = w_ctrl[DEPTH-1].memread;
  assign MemWrite_out_from_EX = w_ctrl[DEPTH-1].memwrite;
  assign alu_out_out          = w_alu[DEPTH-1];
  assign mem_wd               = w_wd[DEPTH-1];
  assign rfile_wn_out         = w_wn[DEPTH-1];

`ifdef EX_MEM_PIPE_FWD_EN
  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;
  logic              w_fwd_load;

  // Scan oldest to youngest so the youngest matching stage overwrites last
  // and therefore wins. Only registered state is searched: the instruction
  // still sitting on the inputs is deliberately invisible here.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_fwd_load = 1'b0;
    if (fwd_rs != REG_AW'(ZERO_REG)) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (w_valid[k] && w_ctrl[k].regwrite && (w_wn[k] == fwd_rs)) begin
          w_fwd_hit  = 1'b1;
          w_fwd_data = w_alu[k];
          w_fwd_load = w_ctrl[k].memread;
        end
      end
    end
  end

  assign fwd_hit  = w_fwd_hit;
  assign fwd_data = w_fwd_data;
  assign fwd_load = w_fwd_load;
`else
  logic w_unused_fwd_rs;
  assign w_unused_fwd_rs = ^fwd_rs;

  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
  assign fwd_load = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench for ex_mem_pipe (DEPTH=3): directed table, forwarding sequence,
// then randomized traffic compared against a slot-level reference model.
module tb_ex_mem_pipe;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int DEPTH  = 3;
`ifdef EX_MEM_PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, en_reg, flush, valid_in;
  logic              MemtoReg_out_from_ID, RegWrite_out_from_ID, MemRead_out_from_ID, MemWrite_out_from_ID;
  logic [DATA_W-1:0] alu_out, rfile_rd2_out;
  logic [REG_AW-1:0] rfile_wn, fwd_rs;
  logic              valid_out;
  logic              MemtoReg_out_from_EX, RegWrite_out_from_EX, MemRead_out_from_EX, MemWrite_out_from_EX;
  logic [DATA_W-1:0] alu_out_out, mem_wd, fwd_data;
  logic [REG_AW-1:0] rfile_wn_out;
  logic              fwd_hit, fwd_load;

  ex_mem_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en_reg(en_reg), .flush(flush), .valid_in(valid_in),
    .MemtoReg_out_from_ID(MemtoReg_out_from_ID), .RegWrite_out_from_ID(RegWrite_out_from_ID),
    .MemRead_out_from_ID(MemRead_out_from_ID), .MemWrite_out_from_ID(MemWrite_out_from_ID),
    .alu_out(alu_out), .rfile_rd2_out(rfile_rd2_out), .rfile_wn(rfile_wn),
    .valid_out(valid_out),
    .MemtoReg_out_from_EX(MemtoReg_out_from_EX), .RegWrite_out_from_EX(RegWrite_out_from_EX),
    .MemRead_out_from_EX(MemRead_out_from_EX), .MemWrite_out_from_EX(MemWrite_out_from_EX),
    .alu_out_out(alu_out_out), .mem_wd(mem_wd), .rfile_wn_out(rfile_wn_out),
    .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_load(fwd_load)
  );

  // ctrl nibble order: {memtoreg, regwrite, memread, memwrite}
  logic [3:0] out_c;
  assign out_c = {MemtoReg_out_from_EX, RegWrite_out_from_EX, MemRead_out_from_EX, MemWrite_out_from_EX};

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: array of in-flight slots ----------------
  logic              m_v   [DEPTH];
  logic [3:0]        m_c   [DEPTH];
  logic [DATA_W-1:0] m_alu [DEPTH];
  logic [DATA_W-1:0] m_wd  [DEPTH];
  logic [REG_AW-1:0] m_wn  [DEPTH];

  task automatic model_clear_slot(input int k);
    m_v[k] = 1'b0; m_c[k] = 4'h0; m_alu[k] = '0; m_wd[k] = '0; m_wn[k] = '0;
  endtask

  task automatic model_step(input logic r, e, f, v, input logic [3:0] c,
                            input logic [DATA_W-1:0] a, w, input logic [REG_AW-1:0] n);
    if (r) begin
      for (int k = 0; k < DEPTH; k++) model_clear_slot(k);
    end else begin
      if (e) begin
        for (int k = DEPTH - 1; k > 0; k--) begin
          m_v[k] = m_v[k-1]; m_c[k] = m_c[k-1]; m_alu[k] = m_alu[k-1];
          m_wd[k] = m_wd[k-1]; m_wn[k] = m_wn[k-1];
        end
      end
      if (f) model_clear_slot(0);
      else if (e) begin
        m_v[0] = v; m_c[0] = v ? c : 4'h0; m_alu[0] = a; m_wd[0] = w; m_wn[0] = n;
      end
    end
  endtask

  task automatic model_fwd(input logic [REG_AW-1:0] rs, output logic hit,
                           output logic [DATA_W-1:0] d, output logic ld);
    hit = 1'b0; d = '0; ld = 1'b0;
    if (FWD && rs != 0) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!hit && m_v[k] && m_c[k][2] && m_wn[k] == rs) begin
          hit = 1'b1; d = m_alu[k]; ld = m_c[k][1];
        end
      end
    end
  endtask

  task automatic check_fwd_model(input string name);
    logic h, l;
    logic [DATA_W-1:0] d;
    model_fwd(fwd_rs, h, d, l);
    check(name, 128'({fwd_hit, fwd_data, fwd_load}), 128'({h, d, l}));
  endtask

  task automatic check_pipe_model(input string name);
    check(name, 128'({valid_out, out_c, alu_out_out, mem_wd, rfile_wn_out}),
          128'({m_v[DEPTH-1], m_c[DEPTH-1], m_alu[DEPTH-1], m_wd[DEPTH-1], m_wn[DEPTH-1]}));
  endtask

  // Drive one cycle of inputs, clock it, update the model, return at the negedge.
  task automatic apply(input logic r, e, f, v, input logic [3:0] c,
                       input logic [DATA_W-1:0] a, w, input logic [REG_AW-1:0] n, rs);
    rst = r; en_reg = e; flush = f; valid_in = v;
    {MemtoReg_out_from_ID, RegWrite_out_from_ID, MemRead_out_from_ID, MemWrite_out_from_ID} = c;
    alu_out = a; rfile_rd2_out = w; rfile_wn = n; fwd_rs = rs;
    @(posedge clk);
    model_step(r, e, f, v, c, a, w, n);
    @(negedge clk);
  endtask

  task automatic fwd_expect(input string name, input logic [REG_AW-1:0] rs,
                            input logic h, input logic [DATA_W-1:0] d, input logic l);
    fwd_rs = rs;
    #1;
    check(name, 128'({fwd_hit, fwd_data, fwd_load}), FWD ? 128'({h, d, l}) : 128'(0));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic rst, en, fl, v;
    logic [3:0] c;
    logic [DATA_W-1:0] alu, wd;
    logic [REG_AW-1:0] wn;
    logic ev;
    logic [3:0] ec;
    logic [DATA_W-1:0] ealu, ewd;
    logic [REG_AW-1:0] ewn;
  } vec_t;

  function automatic vec_t mk(input logic r, e, f, v, input logic [3:0] c,
                              input logic [31:0] a, w, input logic [4:0] n,
                              input logic ev, input logic [3:0] ec,
                              input logic [31:0] ea, ew, input logic [4:0] en);
    vec_t t;
    t.rst = r; t.en = e; t.fl = f; t.v = v; t.c = c; t.alu = a; t.wd = w; t.wn = n;
    t.ev = ev; t.ec = ec; t.ealu = ea; t.ewd = ew; t.ewn = en;
    return t;
  endfunction

  vec_t tbl [18];

  initial begin
    // Inputs at time 0: reset asserted with everything else nonzero.
    rst = 1'b1; en_reg = 1'b1; flush = 1'b1; valid_in = 1'b1;
    {MemtoReg_out_from_ID, RegWrite_out_from_ID, MemRead_out_from_ID, MemWrite_out_from_ID} = 4'hF;
    alu_out = '1; rfile_rd2_out = '1; rfile_wn = '1; fwd_rs = '1;
    for (int k = 0; k < DEPTH; k++) model_clear_slot(k);

    //            rst en fl v  ctrl  alu         wd          wn     | ev ctrl ealu       ewd        ewn
    tbl[0]  = mk(1, 1, 1, 1, 4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h1F, 0, 4'h0, 32'h0,    32'h0,     5'h0);
    tbl[1]  = mk(0, 1, 0, 1, 4'h4, 32'h11,   32'h111,  5'h01, 0, 4'h0, 32'h0,    32'h0,     5'h0);
    tbl[2]  = mk(0, 1, 0, 1, 4'h4, 32'h22,   32'h122,  5'h02, 0, 4'h0, 32'h0,    32'h0,     5'h0);
    tbl[3]  = mk(0, 1, 0, 1, 4'h4, 32'h33,   32'h133,  5'h03, 1, 4'h4, 32'h11,   32'h111,   5'h01);
    tbl[4]  = mk(0, 0, 0, 1, 4'h4, 32'h44,   32'h144,  5'h04, 1, 4'h4, 32'h11,   32'h111,   5'h01);
    tbl[5]  = mk(0, 0, 0, 1, 4'h4, 32'h55,   32'h155,  5'h05, 1, 4'h4, 32'h11,   32'h111,   5'h01);
    tbl[6]  = mk(0, 0, 0, 1, 4'h4, 32'h66,   32'h166,  5'h06, 1, 4'h4, 32'h11,   32'h111,   5'h01);
    tbl[7]  = mk(0, 1, 0, 1, 4'h4, 32'h77,   32'h177,  5'h07, 1, 4'h4, 32'h22,   32'h122,   5'h02);
    tbl[8]  = mk(0, 1, 1, 1, 4'h1, 32'hDEAD, 32'hBEEF, 5'h08, 1, 4'h4, 32'h33,   32'h133,   5'h03);
    tbl[9]  = mk(0, 1, 0, 1, 4'h4, 32'h99,   32'h199,  5'h09, 1, 4'h4, 32'h77,   32'h177,   5'h07);
    tbl[10] = mk(0, 1, 0, 0, 4'hF, 32'hAA,   32'h1AA,  5'h0A, 0, 4'h0, 32'h0,    32'h0,     5'h0);
    tbl[11] = mk(0, 1, 0, 1, 4'h2, 32'hBB,   32'h1BB,  5'h0B, 1, 4'h4, 32'h99,   32'h199,   5'h09);
    tbl[12] = mk(0, 0, 1, 1, 4'h4, 32'hCC,   32'h1CC,  5'h0C, 1, 4'h4, 32'h99,   32'h199,   5'h09);
    tbl[13] = mk(0, 0, 1, 1, 4'h4, 32'hCC,   32'h1CC,  5'h0C, 1, 4'h4, 32'h99,   32'h199,   5'h09);
    tbl[14] = mk(0, 1, 0, 1, 4'hA, 32'hEE,   32'h1EE,  5'h0E, 0, 4'h0, 32'hAA,   32'h1AA,   5'h0A);
    tbl[15] = mk(0, 1, 0, 1, 4'h4, 32'hF1,   32'h1F1,  5'h11, 0, 4'h0, 32'h0,    32'h0,     5'h0);
    tbl[16] = mk(0, 1, 0, 1, 4'h4, 32'hF2,   32'h1F2,  5'h12, 1, 4'hA, 32'hEE,   32'h1EE,   5'h0E);
    tbl[17] = mk(1, 1, 0, 1, 4'h4, 32'hF3,   32'h1F3,  5'h13, 0, 4'h0, 32'h0,    32'h0,     5'h0);

    for (int i = 0; i < 18; i++) begin
      apply(tbl[i].rst, tbl[i].en, tbl[i].fl, tbl[i].v, tbl[i].c,
            tbl[i].alu, tbl[i].wd, tbl[i].wn, tbl[i].wn);
      check($sformatf("vec%0d_pipe", i),
            128'({valid_out, out_c, alu_out_out, mem_wd, rfile_wn_out}),
            128'({tbl[i].ev, tbl[i].ec, tbl[i].ealu, tbl[i].ewd, tbl[i].ewn}));
      check_fwd_model($sformatf("vec%0d_fwd", i));
    end

    // ---------------- forwarding sequence ----------------
    apply(1, 1, 0, 0, 4'h0, 32'h0, 32'h0, 5'h0, 5'h0);
    apply(0, 1, 0, 1, 4'h4, 32'hB, 32'h0, 5'd5, 5'd5);   // ends in stage 2
    apply(0, 1, 0, 1, 4'h4, 32'hC, 32'h0, 5'd6, 5'd5);   // ends in stage 1
    apply(0, 1, 0, 1, 4'h6, 32'hA, 32'h0, 5'd5, 5'd5);   // stage 0, load
    apply(0, 0, 0, 1, 4'h4, 32'h77, 32'h0, 5'd7, 5'd5);  // stalled; wn=7 only on inputs
    fwd_expect("fwd_youngest_load", 5'd5, 1'b1, 32'hA, 1'b1);
    fwd_expect("fwd_mid",           5'd6, 1'b1, 32'hC, 1'b0);
    fwd_expect("fwd_no_bypass",     5'd7, 1'b0, 32'h0, 1'b0);
    fwd_expect("fwd_reg0",          5'd0, 1'b0, 32'h0, 1'b0);
    fwd_expect("fwd_miss",          5'd9, 1'b0, 32'h0, 1'b0);
    apply(0, 0, 1, 1, 4'h4, 32'h77, 32'h0, 5'd7, 5'd5);  // stall+flush: stage 0 emptied
    fwd_expect("fwd_after_flush",   5'd5, 1'b1, 32'hB, 1'b0);
    apply(0, 1, 0, 1, 4'h4, 32'h5, 32'h0, 5'd0, 5'd0);   // regwrite to r0 enters stage 0
    fwd_expect("fwd_r0_inflight",   5'd0, 1'b0, 32'h0, 1'b0);
    fwd_expect("fwd_old_shift",     5'd6, 1'b1, 32'hC, 1'b0);
    fwd_expect("fwd_shifted_out",   5'd5, 1'b0, 32'h0, 1'b0);

    // ---------------- randomized traffic ----------------
    for (int i = 0; i < 400; i++) begin
      logic r, e, f, v;
      logic [3:0] c;
      logic [REG_AW-1:0] n, rs;
      r = ($urandom_range(0, 31) == 0);
      e = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 5) == 0);
      v = ($urandom_range(0, 3) != 0);
      c = 4'($urandom_range(0, 15));
      n = REG_AW'($urandom_range(0, 7));
      rs = REG_AW'($urandom_range(0, 7));
      apply(r, e, f, v, c, $urandom, $urandom, n, rs);
      check_pipe_model($sformatf("rnd%0d_pipe", i));
      check_fwd_model($sformatf("rnd%0d_fwd", i));
      fwd_rs = REG_AW'($urandom_range(0, 7));
      #1;
      check_fwd_model($sformatf("rnd%0d_fwd_rs_change", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
